// File: rtl/vector_pkg.sv
// Shared vector-unit types and widths used by decode, issue and the execution unit.
package vector_pkg;
  localparam int NUM_VREG = 32;
  localparam int OPC_W    = 6;
  localparam int REG_W    = $clog2(NUM_VREG);

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] vd;
    logic [REG_W-1:0] vs1;
    logic [REG_W-1:0] vs2;
  } vinstr_t;
endpackage

// File: rtl/iissue_fifo.sv
// DEPTH-entry instruction FIFO; occupancy counter disambiguates full from empty.
module iissue_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  vector_pkg::vinstr_t din,
  output vector_pkg::vinstr_t dout,
  output logic [PW:0]       count,
  output logic              full,
  output logic              empty
);
  import vector_pkg::*;

  vinstr_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // power-of-2 depth: pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/iissue_unit.sv
// In-order vector issue stage: FIFO, per-vreg busy scoreboard, valid/ready issue.
// Optional hazard stall counter enabled by ISSUE_STALL_CNT_EN.
module iissue_unit #(
  parameter int DEPTH    = 4,
  parameter int NUM_VREG = 32,
  parameter int OPC_W    = 6,
  parameter int REG_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPC_W-1:0]         in_opc,
  input  logic [REG_W-1:0]         in_vd,
  input  logic [REG_W-1:0]         in_vs1,
  input  logic [REG_W-1:0]         in_vs2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPC_W-1:0]         out_opc,
  output logic [REG_W-1:0]         out_vd,
  output logic [REG_W-1:0]         out_vs1,
  output logic [REG_W-1:0]         out_vs2,
  input  logic                     wb_valid,
  input  logic [REG_W-1:0]         wb_vd,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stall_cnt
);
  import vector_pkg::*;

  vinstr_t             din, head;
  logic                full, empty, push, pop, hazard;
  logic [NUM_VREG-1:0] busy, busy_nxt;

  assign din      = '{opc: in_opc, vd: in_vd, vs1: in_vs1, vs2: in_vs2};
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  iissue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // RAW on sources and WAW on destination, from registered busy only
  assign hazard    = busy[head.vs1] | busy[head.vs2] | busy[head.vd];
  assign out_valid = !empty && !hazard;
  assign pop       = out_valid && out_ready;
  assign out_opc   = head.opc;
  assign out_vd    = head.vd;
  assign out_vs1   = head.vs1;
  assign out_vs2   = head.vs2;

  // clear before set so an issue to the released vreg keeps it busy
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_vd] = 1'b0;
    if (pop)      busy_nxt[head.vd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset)                                      stall_q <= '0;
    else if (!empty && hazard && stall_q != '1)     stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_iissue_unit.sv
// Bench for iissue_unit: directed table, hand sequences and random traffic vs a queue model.
module tb_iissue_unit;
  import vector_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, in_ready, out_valid, out_ready, wb_valid;
  logic [5:0] in_opc, out_opc;
  logic [4:0] in_vd, in_vs1, in_vs2, out_vd, out_vs1, out_vs2, wb_vd;
  logic [2:0] count;
  logic [31:0] stall_cnt;

  iissue_unit #(.DEPTH(DEPTH), .NUM_VREG(32), .OPC_W(6), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_opc(out_opc),
    .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2),
    .wb_valid(wb_valid), .wb_vd(wb_vd), .count(count), .stall_cnt(stall_cnt)
  );

  int errs = 0, checks = 0;

  // reference model: instruction queue, busy set, stall counter
  vinstr_t     q[$];
  logic [31:0] bm;
  logic [31:0] stall_m;

  // inputs of the cycle currently being driven, consumed by advance()
  logic    c_iv, c_ordy, c_wbv, c_rst, c_ev, c_hz;
  vinstr_t c_ins, c_head;
  logic [4:0] c_wbvd;

  function automatic vinstr_t mk(int opc, int vd, int vs1, int vs2);
    vinstr_t r;
    r.opc = 6'(opc); r.vd = 5'(vd); r.vs1 = 5'(vs1); r.vs2 = 5'(vs2);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input vinstr_t ins, input logic ordy,
                       input logic wbv = 1'b0, input logic [4:0] wbvd = 5'd0,
                       input logic rst = 1'b0);
    @(negedge clk);
    in_valid = iv; in_opc = ins.opc; in_vd = ins.vd; in_vs1 = ins.vs1; in_vs2 = ins.vs2;
    out_ready = ordy; wb_valid = wbv; wb_vd = wbvd; reset = rst;
    c_iv = iv; c_ins = ins; c_ordy = ordy; c_wbv = wbv; c_wbvd = wbvd; c_rst = rst;
    #1;
    c_hz = 1'b0;
    c_head = '0;
    if (q.size() != 0) begin
      c_head = q[0];
      c_hz = bm[c_head.vs1] | bm[c_head.vs2] | bm[c_head.vd];
    end
    c_ev = (q.size() != 0) && !c_hz;
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(c_ev));
    if (c_ev) begin
      chk("out_opc", 32'(out_opc), 32'(c_head.opc));
      chk("out_vd",  32'(out_vd),  32'(c_head.vd));
      chk("out_vs1", 32'(out_vs1), 32'(c_head.vs1));
      chk("out_vs2", 32'(out_vs2), 32'(c_head.vs2));
    end
    chk("stall_cnt", stall_cnt, stall_m);
  endtask

  task automatic advance();
    logic was_full;
    @(posedge clk);
    if (c_rst) begin
      q.delete(); bm = '0; stall_m = '0;
    end else begin
`ifdef ISSUE_STALL_CNT_EN
      if (q.size() != 0 && c_hz && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
      was_full = (q.size() == DEPTH);
      if (c_wbv) bm[c_wbvd] = 1'b0;
      if (c_ev && c_ordy) begin
        bm[c_head.vd] = 1'b1;
        void'(q.pop_front());
      end
      if (c_iv && !was_full) q.push_back(c_ins);
    end
  endtask

  task automatic step(input logic iv, input vinstr_t ins, input logic ordy,
                      input logic wbv = 1'b0, input logic [4:0] wbvd = 5'd0,
                      input logic rst = 1'b0);
    drive(iv, ins, ordy, wbv, wbvd, rst);
    advance();
  endtask

  typedef struct {
    logic       iv;
    vinstr_t    ins;
    logic       ordy;
    logic       wbv;
    logic [4:0] wbvd;
    int         e_cnt;
    logic       e_ov;
    logic       e_ird;
    logic [4:0] e_vd;
  } vec_t;

  vec_t tbl[9];
  vinstr_t nop;

  initial begin
    nop = '0;
    reset = 1'b1; in_valid = 0; out_ready = 0; wb_valid = 0; wb_vd = 0;
    in_opc = 0; in_vd = 0; in_vs1 = 0; in_vs2 = 0;
    q.delete(); bm = '0; stall_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    // RAW: v1<-v2+v3 issues, then v4<-v1+v5 waits for wb of v1
    tbl[0] = '{1, mk(1, 1, 2, 3), 1, 0, 0, 0, 0, 1, 0};
    tbl[1] = '{0, nop,            1, 0, 0, 1, 1, 1, 1};
    tbl[2] = '{1, mk(2, 4, 1, 5), 1, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{0, nop,            1, 0, 0, 1, 0, 1, 0};
    tbl[4] = '{0, nop,            1, 0, 0, 1, 0, 1, 0};
    tbl[5] = '{0, nop,            1, 1, 1, 1, 0, 1, 0};
    tbl[6] = '{0, nop,            1, 0, 0, 1, 1, 1, 4};
    tbl[7] = '{0, nop,            1, 0, 0, 0, 0, 1, 0};
    tbl[8] = '{0, nop,            1, 1, 4, 0, 0, 1, 0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].iv, tbl[i].ins, tbl[i].ordy, tbl[i].wbv, tbl[i].wbvd);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ird));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_vd", i), 32'(out_vd), 32'(tbl[i].e_vd));
      advance();
    end

    // fill to full, refuse a 5th, then drain in order
    step(0, nop, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, mk(10 + i, 8 + i, 16 + i, 20 + i), 0);
    drive(1, mk(20, 12, 0, 0), 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    advance();
    #1 chk("refused_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, nop, 1);
      chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_opc", i), 32'(out_opc), 32'(10 + i));
      advance();
    end
    #1 chk("drained_count", 32'(count), 32'd0);

    // WAW on v7
    step(0, nop, 0, 0, 0, 1);
    step(1, mk(30, 7, 1, 2), 1);
    step(1, mk(31, 7, 3, 4), 1);
    drive(0, nop, 1);
    chk("waw_blocked", 32'(out_valid), 32'd0);
    advance();
    step(0, nop, 1);
    step(0, nop, 1, 1, 7);
    drive(0, nop, 1);
    chk("waw_released", 32'(out_valid), 32'd1);
    chk("waw_opc", 32'(out_opc), 32'd31);
    advance();

    // simultaneous push and pop at count 2, then a long stream across wraps
    step(0, nop, 0, 0, 0, 1);
    step(1, mk(1, 8, 0, 1), 0);
    step(1, mk(2, 9, 0, 1), 0);
    drive(1, mk(3, 10, 0, 1), 1);
    chk("pp_count_before", 32'(count), 32'd2);
    advance();
    #1 chk("pp_count_after", 32'(count), 32'd2);
    for (int i = 0; i < 3 * DEPTH; i++) step(1, mk(40 + i, 12 + i, 0, 1), (i % 3) != 0);
    repeat (DEPTH + 1) step(0, nop, 1);

    // reset with 3 queued and v1, v2 busy
    step(0, nop, 0, 0, 0, 1);
    step(1, mk(1, 1, 0, 0), 1);
    step(1, mk(2, 2, 0, 0), 1);
    step(1, mk(3, 5, 1, 0), 1);
    step(1, mk(4, 6, 0, 0), 0);
    step(1, mk(5, 7, 0, 0), 0);
    drive(0, nop, 0);
    chk("prerst_count", 32'(count), 32'd3);
    advance();
    step(0, nop, 0, 1, 1, 1);
    #1 chk("postrst_count", 32'(count), 32'd0);
    step(1, mk(6, 3, 1, 2), 0);
    drive(0, nop, 0);
    chk("postrst_busy_clear", 32'(out_valid), 32'd1);
    advance();

    // 5-cycle hazard for the stall counter
    step(0, nop, 0, 0, 0, 1);
    step(1, mk(50, 9, 0, 0), 1);
    step(1, mk(51, 3, 9, 0), 1);
    repeat (5) step(0, nop, 1);
`ifdef ISSUE_STALL_CNT_EN
    #1 chk("stall5", stall_cnt, 32'd5);
`else
    #1 chk("stall_tied0", stall_cnt, 32'd0);
`endif
    step(0, nop, 1, 1, 9);
    repeat (2) step(0, nop, 1);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 1) == 1,
           mk($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
           ($urandom % 4) != 0,
           ($urandom % 3) == 0, 5'($urandom_range(0, 7)),
           ($urandom % 300) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
